// File: rtl/lsu_wb_master_if.sv
// -----------------------------------------------------------------------------
// lsu_wb_master_if
// Wishbone (classic/pipelined) data-port bundle between the memory-stage
// load/store unit and the unified main memory.
//
// Signals:
//   wb_cyc      initiator -> responder  bus cycle active
//   wb_stb      initiator -> responder  request strobe
//   wb_wr_en    initiator -> responder  write enable
//   wb_addr     initiator -> responder  word-aligned byte address
//   wb_wr_data  initiator -> responder  lane-replicated store data
//   wb_sel      initiator -> responder  byte-lane select
//   wb_ack      responder -> initiator  acknowledge
//   wb_stall    responder -> initiator  strobe not accepted this cycle
//   wb_rd_data  responder -> initiator  read word
// -----------------------------------------------------------------------------
interface lsu_wb_master_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_wr_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [31:0]           wb_wr_data;
    logic [3:0]            wb_sel;
    logic                  wb_ack;
    logic                  wb_stall;
    logic [31:0]           wb_rd_data;

    modport master (
        output wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_sel,
        input  wb_ack, wb_stall, wb_rd_data
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_sel,
        output wb_ack, wb_stall, wb_rd_data
    );
endinterface

// File: rtl/lsu_wb_master.sv
// -----------------------------------------------------------------------------
// lsu_wb_master
// Memory-stage load/store unit. Takes one RV32I load or store from stage 4,
// issues a single Wishbone cycle, builds byte lanes / replicated write data
// for stores and aligns plus sign/zero-extends read data for loads. Stalls the
// pipeline until the access completes, faults on misalignment or times out.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_req         stage 4 holds a load/store (stable until mem_done)
//   mem_we          1 = store, 0 = load
//   mem_funct3      RV32I size/sign code (reserved codes behave as W)
//   mem_addr        byte address
//   mem_wdata       store source
//   mem_stall       combinational pipeline freeze
//   mem_done        one-cycle completion pulse
//   mem_rdata       extended load result (0 for stores and faults)
//   mem_misaligned  with mem_done: address misaligned for the access size
//   mem_bus_err     with mem_done: acknowledge timeout
//   wb              Wishbone initiator side (lsu_wb_master_if.master)
// -----------------------------------------------------------------------------
module lsu_wb_master #(
    parameter int ADDR_WIDTH  = 10,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [2:0]            mem_funct3,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_stall,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  mem_misaligned,
    output logic                  mem_bus_err,
    lsu_wb_master_if.master       wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access size; funct3 codes without a meaning for the direction act as W.
    function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            3'b000:  sz = SZ_B;
            3'b001:  sz = SZ_H;
            3'b100:  sz = we ? SZ_W : SZ_B;
            3'b101:  sz = we ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_sel(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] sel;
        case (sz)
            SZ_B:    sel = 4'b0001 << off;
            SZ_H:    sel = off[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Replicate the source across lanes so the responder only needs wb_sel.
    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wdata);
        logic [31:0] data;
        case (sz)
            SZ_B:    data = {4{wdata[7:0]}};
            SZ_H:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b100:  res = {24'h000000, sh_b[7:0]};
            3'b001:  res = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b101:  res = {16'h0000, sh_h[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [3:0]            sel_q, sel_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic                  done_q, done_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;

    logic [1:0]            req_size_s;
    logic                  req_misaligned_s;
    logic                  timeout_s;
    logic                  req_accept_ack_s;
    logic [31:0]           load_result_s;

    assign req_size_s       = access_size(mem_we, mem_funct3);
    assign req_misaligned_s = is_misaligned(req_size_s, mem_addr[1:0]);
    assign timeout_s        = (cnt_q == CNT_LAST);
    // An ack is only meaningful in REQ once the strobe is actually accepted.
    assign req_accept_ack_s = wb.wb_ack & ~wb.wb_stall;
    assign load_result_s    = wr_en_q ? 32'h00000000 : load_extend(funct3_q, off_q, wb.wb_rd_data);

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= 32'h00000000;
            sel_q     <= 4'b0000;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            done_q    <= 1'b0;
            rdata_q   <= 32'h00000000;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
        end
    end

    // Next-state selection; ack has priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d = req_misaligned_s ? ST_DONE : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_accept_ack_s) begin
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                end else if (!wb.wb_stall) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (wb.wb_ack || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and completion outputs.
    always_comb begin
        cnt_d     = cnt_q;
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        sel_d     = sel_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        done_d    = 1'b0;
        rdata_d   = 32'h00000000;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req && req_misaligned_s) begin
                    done_d = 1'b1;
                    mis_d  = 1'b1;
                end else if (mem_req) begin
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    wr_en_d   = mem_we;
                    addr_d    = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                    wr_data_d = mem_we ? store_data(req_size_s, mem_wdata) : 32'h00000000;
                    sel_d     = mem_we ? store_sel(req_size_s, mem_addr[1:0]) : 4'b1111;
                    funct3_d  = mem_funct3;
                    off_d     = mem_addr[1:0];
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (req_accept_ack_s) begin
                    done_d  = 1'b1;
                    rdata_d = load_result_s;
                end else if (timeout_s) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    cyc_d   = 1'b1;
                    stb_d   = wb.wb_stall;
                    wr_en_d = wr_en_q;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wb.wb_ack) begin
                    done_d  = 1'b1;
                    rdata_d = load_result_s;
                end else if (timeout_s) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    cyc_d   = 1'b1;
                    wr_en_d = wr_en_q;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign mem_stall      = ((state_q == ST_IDLE) & mem_req) |
                            (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign mem_done       = done_q;
    assign mem_rdata      = rdata_q;
    assign mem_misaligned = mis_q;
    assign mem_bus_err    = err_q;

    assign wb.wb_cyc      = cyc_q;
    assign wb.wb_stb      = stb_q;
    assign wb.wb_wr_en    = wr_en_q;
    assign wb.wb_addr     = addr_q;
    assign wb.wb_wr_data  = wr_data_q;
    assign wb.wb_sel      = sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
module tb_lsu_wb_master;
    localparam int AW  = 10;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_req, mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_stall, mem_done, mem_misaligned, mem_bus_err;
    logic [31:0]   mem_rdata;

    lsu_wb_master_if #(.ADDR_WIDTH(AW)) wb_bus ();

    lsu_wb_master #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_stall      (mem_stall),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .mem_misaligned (mem_misaligned),
        .mem_bus_err    (mem_bus_err),
        .wb             (wb_bus)
    );

    // ---------------- pipelined responder ----------------
    logic [31:0] rsp_mem [0:255];
    logic        preload;
    logic        no_ack;
    int          stall_budget;
    int          stb_age;
    logic        ack_r;
    logic [31:0] rd_r;

    function automatic logic [31:0] seed_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    assign wb_bus.wb_stall   = wb_bus.wb_cyc & wb_bus.wb_stb & (stb_age < stall_budget);
    assign wb_bus.wb_ack     = ack_r;
    assign wb_bus.wb_rd_data = rd_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            rd_r    <= 32'h0;
            stb_age <= 0;
        end else if (preload) begin
            for (int i = 0; i < 256; i++) rsp_mem[i] <= seed_word(i);
        end else begin
            ack_r <= 1'b0;
            rd_r  <= 32'h0;
            if (wb_bus.wb_cyc && wb_bus.wb_stb) begin
                if (stb_age < stall_budget) begin
                    stb_age <= stb_age + 1;
                end else begin
                    stb_age <= 0;
                    if (!no_ack) begin
                        ack_r <= 1'b1;
                        rd_r  <= rsp_mem[wb_bus.wb_addr[AW-1:2]];
                        if (wb_bus.wb_wr_en)
                            for (int b = 0; b < 4; b++)
                                if (wb_bus.wb_sel[b])
                                    rsp_mem[wb_bus.wb_addr[AW-1:2]][8*b +: 8] <= wb_bus.wb_wr_data[8*b +: 8];
                    end
                end
            end else begin
                stb_age <= 0;
            end
        end
    end

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0] ref_mem [0:1023];

    function automatic int ref_size(input logic we, input logic [2:0] f3);
        if (f3 == 3'b000 || (!we && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!we && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [AW-1:0] a);
        int sz;
        logic [31:0] v;
        sz = ref_size(1'b0, f3);
        v  = 32'h0;
        for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd);
        int sz;
        logic [31:0] tmp;
        sz  = ref_size(1'b1, f3);
        tmp = wd;
        for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = tmp[8*k +: 8];
    endtask

    // ---------------- access driver / observation ----------------
    int errors = 0;
    int checks = 0;

    logic [31:0]   obs_rd;
    logic          obs_mis, obs_err, obs_cyc_at_done;
    int            obs_lat, obs_stall_cnt, obs_stb_cnt;
    logic          obs_addr_stable, obs_any_cyc;
    logic          obs_n1_cyc, obs_n1_stb, obs_n1_we;
    logic [3:0]    obs_n1_sel;
    logic [AW-1:0] obs_n1_addr;
    logic [31:0]   obs_n1_wdata;

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                             input logic [31:0] wd);
        logic [AW-1:0] first_addr;
        logic          have_first;
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
        #1;
        obs_lat = 0; obs_stall_cnt = 0; obs_stb_cnt = 0; obs_addr_stable = 1'b1;
        obs_any_cyc = 1'b0; have_first = 1'b0; first_addr = '0;
        obs_rd = 32'hx; obs_mis = 1'bx; obs_err = 1'bx; obs_cyc_at_done = 1'bx;
        for (int i = 0; i < 64; i++) begin
            if (mem_stall) obs_stall_cnt++;
            if (wb_bus.wb_cyc) obs_any_cyc = 1'b1;
            if (wb_bus.wb_stb) begin
                obs_stb_cnt++;
                if (!have_first) begin
                    first_addr = wb_bus.wb_addr;
                    have_first = 1'b1;
                end else if (wb_bus.wb_addr !== first_addr) begin
                    obs_addr_stable = 1'b0;
                end
            end
            if (i == 1) begin
                obs_n1_cyc = wb_bus.wb_cyc; obs_n1_stb = wb_bus.wb_stb; obs_n1_we = wb_bus.wb_wr_en;
                obs_n1_sel = wb_bus.wb_sel; obs_n1_addr = wb_bus.wb_addr; obs_n1_wdata = wb_bus.wb_wr_data;
            end
            if (mem_done) begin
                obs_rd = mem_rdata; obs_mis = mem_misaligned; obs_err = mem_bus_err;
                obs_cyc_at_done = wb_bus.wb_cyc;
                break;
            end
            @(negedge clk); #1;
            obs_lat++;
        end
        mem_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({wb_bus.wb_cyc, wb_bus.wb_stb, wb_bus.wb_wr_en, wb_bus.wb_addr, wb_bus.wb_wr_data, wb_bus.wb_sel} !== '0) begin
            errors++;
            $display("FAIL reset_bus got cyc=%b stb=%b we=%b addr=%h wd=%h sel=%b want all 0",
                     wb_bus.wb_cyc, wb_bus.wb_stb, wb_bus.wb_wr_en, wb_bus.wb_addr, wb_bus.wb_wr_data, wb_bus.wb_sel);
        end
        checks++;
        if ({mem_done, mem_rdata, mem_misaligned, mem_bus_err, mem_stall} !== '0) begin
            errors++;
            $display("FAIL reset_mem got done=%b rd=%h mis=%b err=%b stall=%b want all 0",
                     mem_done, mem_rdata, mem_misaligned, mem_bus_err, mem_stall);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        do_access(1'b1, 3'b010, 10'h010, 32'hDEADBEEF);
        ref_store(3'b010, 10'h010, 32'hDEADBEEF);
        checks++;
        if ({obs_n1_cyc, obs_n1_stb, obs_n1_we, obs_n1_sel} !== 7'b111_1111) begin
            errors++;
            $display("FAIL sw_bus_n1 got cyc/stb/we/sel=%b%b%b%b want 1111111", obs_n1_cyc, obs_n1_stb, obs_n1_we, obs_n1_sel);
        end
        checks++;
        if (obs_n1_addr !== 10'h010 || obs_n1_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_addr_data got addr=%h wd=%h want 010 DEADBEEF", obs_n1_addr, obs_n1_wdata);
        end
        checks++;
        if (obs_lat != 3 || obs_stall_cnt != 3) begin
            errors++;
            $display("FAIL sw_timing got lat=%0d stall=%0d want 3 3", obs_lat, obs_stall_cnt);
        end
        checks++;
        if (obs_rd !== 32'h0 || obs_mis !== 1'b0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_result got rd=%h mis=%b err=%b want 0 0 0", obs_rd, obs_mis, obs_err);
        end
        do_access(1'b0, 3'b010, 10'h010, 32'h0);
        checks++;
        if (obs_rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_readback got %h want DEADBEEF", obs_rd);
        end
    endtask

    task automatic test_store_lanes();
        do_access(1'b1, 3'b000, 10'h013, 32'h000000AB);
        ref_store(3'b000, 10'h013, 32'h000000AB);
        checks++;
        if (obs_n1_wdata !== 32'hABABABAB || obs_n1_sel !== 4'b1000) begin
            errors++;
            $display("FAIL sb_lanes got wd=%h sel=%b want ABABABAB 1000", obs_n1_wdata, obs_n1_sel);
        end
        do_access(1'b1, 3'b001, 10'h012, 32'h00001234);
        ref_store(3'b001, 10'h012, 32'h00001234);
        checks++;
        if (obs_n1_wdata !== 32'h12341234 || obs_n1_sel !== 4'b1100) begin
            errors++;
            $display("FAIL sh_lanes got wd=%h sel=%b want 12341234 1100", obs_n1_wdata, obs_n1_sel);
        end
        do_access(1'b0, 3'b010, 10'h010, 32'h0);
        checks++;
        if (obs_rd !== 32'h1234BEEF) begin
            errors++;
            $display("FAIL lanes_readback got %h want 1234BEEF", obs_rd);
        end
    endtask

    task automatic test_loads();
        logic [2:0]    f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [AW-1:0] addrs [5] = '{10'h010, 10'h010, 10'h012, 10'h012, 10'h010};
        logic [31:0]   wants [5] = '{32'hFFFFFFA1, 32'h000000A1, 32'hFFFF8765, 32'h00008765, 32'h876543A1};
        do_access(1'b1, 3'b010, 10'h010, 32'h876543A1);
        ref_store(3'b010, 10'h010, 32'h876543A1);
        for (int i = 0; i < 5; i++) begin
            do_access(1'b0, f3s[i], addrs[i], 32'hFFFFFFFF);
            checks++;
            if (obs_rd !== wants[i] || obs_rd !== ref_load(f3s[i], addrs[i])) begin
                errors++;
                $display("FAIL load_%0d got %h want %h", i, obs_rd, wants[i]);
            end
            if (i == 0) begin
                checks++;
                if (obs_n1_we !== 1'b0 || obs_n1_sel !== 4'b1111 || obs_n1_wdata !== 32'h0) begin
                    errors++;
                    $display("FAIL load_bus got we=%b sel=%b wd=%h want 0 1111 0", obs_n1_we, obs_n1_sel, obs_n1_wdata);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]    f3s   [2] = '{3'b010, 3'b001};
        logic [AW-1:0] addrs [2] = '{10'h012, 10'h011};
        for (int i = 0; i < 2; i++) begin
            do_access(1'b0, f3s[i], addrs[i], 32'h0);
            checks++;
            if (obs_any_cyc !== 1'b0 || obs_lat != 1 || obs_mis !== 1'b1 || obs_err !== 1'b0 || obs_rd !== 32'h0) begin
                errors++;
                $display("FAIL misaligned_%0d got cyc=%b lat=%0d mis=%b err=%b rd=%h want 0 1 1 0 0",
                         i, obs_any_cyc, obs_lat, obs_mis, obs_err, obs_rd);
            end
        end
    endtask

    task automatic test_stall();
        stall_budget = 2;
        do_access(1'b0, 3'b010, 10'h010, 32'h0);
        stall_budget = 0;
        checks++;
        if (obs_stb_cnt != 3 || obs_addr_stable !== 1'b1 || obs_lat != 5) begin
            errors++;
            $display("FAIL stall_hold got stb=%0d stable=%b lat=%0d want 3 1 5", obs_stb_cnt, obs_addr_stable, obs_lat);
        end
        checks++;
        if (obs_rd !== 32'h876543A1) begin
            errors++;
            $display("FAIL stall_data got %h want 876543A1", obs_rd);
        end
    endtask

    task automatic test_timeout();
        no_ack = 1'b1;
        do_access(1'b0, 3'b010, 10'h010, 32'h0);
        no_ack = 1'b0;
        checks++;
        if (obs_lat != 1 + TMO || obs_err !== 1'b1 || obs_mis !== 1'b0 || obs_rd !== 32'h0 || obs_cyc_at_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout got lat=%0d err=%b mis=%b rd=%h cyc=%b want %0d 1 0 0 0",
                     obs_lat, obs_err, obs_mis, obs_rd, obs_cyc_at_done, 1 + TMO);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        no_ack = 1'b1;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b010; mem_addr = 10'h010;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (wb_bus.wb_cyc !== 1'b1 || wb_bus.wb_stb !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait got cyc=%b stb=%b want 1 0", wb_bus.wb_cyc, wb_bus.wb_stb);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wb_bus.wb_cyc !== 1'b0 || wb_bus.wb_stb !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop got cyc=%b stb=%b want 0 0", wb_bus.wb_cyc, wb_bus.wb_stb);
        end
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        no_ack = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL rstmid_nodone got %0d done pulses want 0", seen_done);
        end
        do_access(1'b0, 3'b010, 10'h010, 32'h0);
        checks++;
        if (obs_rd !== 32'h876543A1 || obs_lat != 3) begin
            errors++;
            $display("FAIL rstmid_after got rd=%h lat=%0d want 876543A1 3", obs_rd, obs_lat);
        end
    endtask

    task automatic test_random();
        logic [2:0]    f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic          we;
        logic [2:0]    f3;
        logic [AW-1:0] a;
        logic [31:0]   wd, exp_rd;
        logic          exp_mis;
        int            sb, exp_lat;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) f3 = 3'b011;
            a  = AW'($urandom_range(0, 1023));
            wd = $urandom;
            sb = $urandom_range(0, 2);
            exp_mis = (int'(a) % ref_size(we, f3)) != 0;
            exp_lat = exp_mis ? 1 : 3 + sb;
            exp_rd  = (exp_mis || we) ? 32'h0 : ref_load(f3, a);
            stall_budget = sb;
            do_access(we, f3, a, wd);
            stall_budget = 0;
            if (we && !exp_mis) ref_store(f3, a, wd);
            checks++;
            if (obs_rd !== exp_rd) begin
                errors++;
                $display("FAIL rand_%0d_rdata we=%b f3=%b a=%h got %h want %h", n, we, f3, a, obs_rd, exp_rd);
            end
            checks++;
            if (obs_mis !== exp_mis || obs_err !== 1'b0 || obs_lat != exp_lat) begin
                errors++;
                $display("FAIL rand_%0d_status got mis=%b err=%b lat=%0d want %b 0 %0d",
                         n, obs_mis, obs_err, obs_lat, exp_mis, exp_lat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_funct3 = 3'b000;
        mem_addr = '0; mem_wdata = 32'h0; no_ack = 1'b0; stall_budget = 0; preload = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = seed_word(i / 4);
            ref_mem[i] = w[8*(i%4) +: 8];
        end
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
